// File: rtl/parking_gate_if.sv
// parking_gate_if: gate sensors and occupancy in, events and barrier commands out
interface parking_gate_if #(parameter int COUNT_W = 10);
  logic entry_req, entry_is_uni, entry_pass, exit_req, exit_is_uni, exit_pass;
  logic uni_is_vacated_space, is_vacated_space;
  logic [COUNT_W-1:0] uni_parked_car, parked_car;
  logic [4:0] hour;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic entry_gate_open, exit_gate_open, entry_rejected, exit_rejected, gate_timeout;
  modport slave(
    input entry_req, entry_is_uni, entry_pass, exit_req, exit_is_uni, exit_pass,
    input uni_is_vacated_space, is_vacated_space, uni_parked_car, parked_car,
    output hour, car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    output entry_gate_open, exit_gate_open, entry_rejected, exit_rejected, gate_timeout
  );
  modport master(
    output entry_req, entry_is_uni, entry_pass, exit_req, exit_is_uni, exit_pass,
    output uni_is_vacated_space, is_vacated_space, uni_parked_car, parked_car,
    input hour, car_entered, is_uni_car_entered, car_exited, is_uni_car_exited,
    input entry_gate_open, exit_gate_open, entry_rejected, exit_rejected, gate_timeout
  );
endinterface

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: entry/exit barrier FSMs producing occupancy events, plus hour-of-day generator
module parking_gate_controller #(
  parameter int CYCLES_PER_HOUR = 400,
  parameter int GATE_TIMEOUT = 64,
  parameter int COUNT_W = 10
) (
  input logic clk,
  input logic rst,
  parking_gate_if.slave gi
);
  localparam int HW = $clog2(CYCLES_PER_HOUR);
  localparam int TW = $clog2(GATE_TIMEOUT + 1);
  localparam logic [2:0] IDLE = 3'd0, CHECK = 3'd1, OPEN = 3'd2, COMMIT = 3'd3, REJECT = 3'd4, CLEAR = 3'd5;
  logic [HW-1:0] hcnt;
  logic [4:0] hour;
  logic [2:0] e_st, e_nx, x_st, x_nx;
  logic [TW-1:0] e_cnt, x_cnt;
  logic e_uni, x_uni, x_pend, tout;
  logic e_space, x_ok, e_commit, e_to, x_pass, x_commit, x_to;
  always_comb begin
    e_space = gi.entry_is_uni ? gi.uni_is_vacated_space : gi.is_vacated_space;
    x_ok = (gi.exit_is_uni ? gi.uni_parked_car : gi.parked_car) != {COUNT_W{1'b0}};
    e_commit = e_st == OPEN && gi.entry_pass;
    e_to = e_st == OPEN && !gi.entry_pass && e_cnt == TW'(GATE_TIMEOUT - 1);
    // exit loses a same-cycle commit to entry and carries its pass forward one cycle
    x_pass = x_st == OPEN && (x_pend || gi.exit_pass);
    x_commit = x_pass && !e_commit;
    x_to = x_st == OPEN && !x_pass && x_cnt == TW'(GATE_TIMEOUT - 1);
    e_nx = e_st == IDLE  ? (gi.entry_req ? CHECK : IDLE) :
           e_st == CHECK ? (e_space ? OPEN : REJECT) :
           e_st == OPEN  ? (e_commit ? COMMIT : e_to ? CLEAR : OPEN) :
           (e_st == CLEAR && !gi.entry_req) ? IDLE : CLEAR;
    x_nx = x_st == IDLE  ? (gi.exit_req ? CHECK : IDLE) :
           x_st == CHECK ? (x_ok ? OPEN : REJECT) :
           x_st == OPEN  ? (x_commit ? COMMIT : x_to ? CLEAR : OPEN) :
           (x_st == CLEAR && !gi.exit_req) ? IDLE : CLEAR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      hour <= '0;
      e_st <= IDLE;
      x_st <= IDLE;
      e_cnt <= '0;
      x_cnt <= '0;
      e_uni <= 1'b0;
      x_uni <= 1'b0;
      x_pend <= 1'b0;
      tout <= 1'b0;
    end else begin
      hcnt <= hcnt == HW'(CYCLES_PER_HOUR - 1) ? '0 : hcnt + 1'b1;
      if (hcnt == HW'(CYCLES_PER_HOUR - 1)) hour <= hour == 5'd23 ? 5'd0 : hour + 5'd1;
      e_st <= e_nx;
      x_st <= x_nx;
      e_cnt <= e_st == OPEN ? e_cnt + 1'b1 : '0;
      x_cnt <= x_st == OPEN ? x_cnt + 1'b1 : '0;
      if (e_st == CHECK) e_uni <= gi.entry_is_uni;
      if (x_st == CHECK) x_uni <= gi.exit_is_uni;
      x_pend <= x_pass && !x_commit;
      tout <= e_to || x_to;
    end
  end
  assign gi.hour = hour;
  assign gi.car_entered = e_st == COMMIT;
  assign gi.car_exited = x_st == COMMIT;
  assign gi.is_uni_car_entered = e_uni;
  assign gi.is_uni_car_exited = x_uni;
  assign gi.entry_gate_open = e_st == OPEN;
  assign gi.exit_gate_open = x_st == OPEN;
  assign gi.entry_rejected = e_st == REJECT;
  assign gi.exit_rejected = x_st == REJECT;
  assign gi.gate_timeout = tout;
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: directed literal checks plus randomized run against a behavioural model
module tb_parking_gate_controller;
  localparam int CPH = 4, GT = 8, CW = 10;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  parking_gate_if #(.COUNT_W(CW)) pif ();
  parking_gate_controller #(.CYCLES_PER_HOUR(CPH), .GATE_TIMEOUT(GT), .COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .gi(pif)
  );
  int passed = 0, total = 0;
  bit armed = 0;
  bit eg, ee, er, ew, ec, eu, xg, xe, xr, xw, xc, xu, xd, mto;
  int eo, xo, hn;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [13:0] outs();
    return {pif.hour, pif.car_entered, pif.is_uni_car_entered, pif.car_exited, pif.is_uni_car_exited,
            pif.entry_gate_open, pif.exit_gate_open, pif.entry_rejected, pif.exit_rejected, pif.gate_timeout};
  endfunction
  function automatic logic [13:0] model_outs();
    return {5'((hn / CPH) % 24), ee, eu, xe, xu, eg, xg, er, xr, mto};
  endfunction
  // Model tracks what each barrier is visibly doing per car presence, not controller states
  always @(posedge clk) begin
    bit e_now, nto;
    e_now = 0;
    nto = 0;
    if (rst) begin
      {eg, ee, er, ew, ec, eu, xg, xe, xr, xw, xc, xu, xd, mto} = '0;
      eo = 0; xo = 0; hn = 0; armed = 1;
    end else begin
      hn++;
      if (ee || er) begin ee = 0; er = 0; ew = 1; end
      else if (ew) ew = pif.entry_req;
      else if (eg) begin
        if (pif.entry_pass) begin eg = 0; ee = 1; e_now = 1; end
        else if (eo == GT - 1) begin eg = 0; ew = 1; nto = 1; end
        else eo++;
      end else if (ec) begin
        ec = 0;
        eu = pif.entry_is_uni;
        if (pif.entry_is_uni ? pif.uni_is_vacated_space : pif.is_vacated_space) begin eg = 1; eo = 0; end
        else er = 1;
      end else if (pif.entry_req) ec = 1;
      if (xe || xr) begin xe = 0; xr = 0; xw = 1; end
      else if (xw) xw = pif.exit_req;
      else if (xg) begin
        if (xd || pif.exit_pass) begin
          if (e_now) begin xd = 1; xo++; end
          else begin xg = 0; xd = 0; xe = 1; end
        end else if (xo == GT - 1) begin xg = 0; xw = 1; nto = 1; end
        else xo++;
      end else if (xc) begin
        xc = 0;
        xu = pif.exit_is_uni;
        if ((pif.exit_is_uni ? pif.uni_parked_car : pif.parked_car) != 0) begin xg = 1; xo = 0; end
        else xr = 1;
      end else if (pif.exit_req) xc = 1;
      mto = nto;
    end
  end
  always @(negedge clk) if (armed) chk("model_cycle", 32'(outs()), 32'(model_outs()));
  initial begin
    int a, b, c;
    {pif.entry_req, pif.entry_is_uni, pif.entry_pass, pif.exit_req, pif.exit_is_uni, pif.exit_pass} = '0;
    {pif.uni_is_vacated_space, pif.is_vacated_space} = '0;
    pif.uni_parked_car = '0;
    pif.parked_car = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", 32'(outs()), 32'd0);
    repeat (4) @(negedge clk);
    chk("hour_1", 32'(pif.hour), 32'd1);
    repeat (91) @(negedge clk);
    chk("hour_23", 32'(pif.hour), 32'd23);
    @(negedge clk);
    chk("hour_wrap", 32'(pif.hour), 32'd0);
    chk("idle_quiet", 32'(outs() & 14'h1ff), 32'd0);
    pif.entry_is_uni = 1; pif.uni_is_vacated_space = 1; pif.entry_req = 1;
    @(negedge clk);
    chk("acc_gate_n1", 32'(pif.entry_gate_open), 32'd0);
    @(negedge clk);
    chk("acc_gate_n2", 32'(pif.entry_gate_open), 32'd1);
    repeat (2) @(negedge clk);
    pif.entry_pass = 1;
    @(negedge clk);
    chk("acc_event", 32'({pif.car_entered, pif.is_uni_car_entered, pif.entry_gate_open}), 32'b110);
    pif.entry_pass = 0; pif.entry_req = 0;
    @(negedge clk);
    chk("acc_event_once", 32'(pif.car_entered), 32'd0);
    repeat (3) @(negedge clk);
    pif.entry_is_uni = 0; pif.is_vacated_space = 0; pif.entry_req = 1;
    a = 0; b = 0;
    repeat (20) begin @(negedge clk); a += pif.entry_rejected; b += pif.entry_gate_open; end
    chk("rej_pulses", 32'(a), 32'd1);
    chk("rej_gate", 32'(b), 32'd0);
    pif.entry_req = 0;
    repeat (3) @(negedge clk);
    pif.is_vacated_space = 1; pif.entry_req = 1;
    a = 0; b = 0; c = 0;
    repeat (20) begin @(negedge clk); a += pif.entry_gate_open; b += pif.gate_timeout; c += pif.car_entered; end
    chk("to_gate_cycles", 32'(a), 32'd8);
    chk("to_pulses", 32'(b), 32'd1);
    chk("to_no_event", 32'(c), 32'd0);
    pif.entry_req = 0;
    repeat (3) @(negedge clk);
    pif.exit_req = 1;
    a = 0; b = 0;
    repeat (10) begin @(negedge clk); a += pif.exit_rejected; b += pif.exit_gate_open; end
    chk("xrej_pulses", 32'(a), 32'd1);
    chk("xrej_gate", 32'(b), 32'd0);
    pif.exit_req = 0;
    repeat (3) @(negedge clk);
    pif.parked_car = 5; pif.exit_req = 1;
    repeat (2) @(negedge clk);
    chk("xacc_gate", 32'(pif.exit_gate_open), 32'd1);
    pif.exit_pass = 1;
    @(negedge clk);
    chk("xacc_event", 32'({pif.car_exited, pif.is_uni_car_exited}), 32'b10);
    pif.exit_pass = 0; pif.exit_req = 0;
    repeat (3) @(negedge clk);
    pif.entry_req = 1; pif.exit_req = 1;
    repeat (2) @(negedge clk);
    chk("col_gates", 32'({pif.entry_gate_open, pif.exit_gate_open}), 32'b11);
    pif.entry_pass = 1; pif.exit_pass = 1;
    @(negedge clk);
    chk("col_t1", 32'({pif.car_entered, pif.car_exited, pif.exit_gate_open}), 32'b101);
    pif.entry_pass = 0; pif.exit_pass = 0;
    @(negedge clk);
    chk("col_t2", 32'({pif.car_entered, pif.car_exited}), 32'b01);
    pif.entry_req = 0; pif.exit_req = 0;
    repeat (3) @(negedge clk);
    pif.entry_req = 1;
    repeat (2) @(negedge clk);
    chk("rst_gate_open", 32'(pif.entry_gate_open), 32'd1);
    rst = 1;
    @(negedge clk);
    chk("rst_all_zero", 32'(outs()), 32'd0);
    rst = 0; pif.entry_req = 0;
    @(negedge clk);
    chk("rst_no_event", 32'(pif.car_entered), 32'd0);
    repeat (3) @(negedge clk);
    repeat (4000) begin
      if ($urandom_range(0, 7) == 0) pif.entry_req = ~pif.entry_req;
      if ($urandom_range(0, 7) == 0) pif.exit_req = ~pif.exit_req;
      pif.entry_pass = $urandom_range(0, 3) == 0;
      pif.exit_pass = $urandom_range(0, 3) == 0;
      pif.entry_is_uni = 1'($urandom_range(0, 1));
      pif.exit_is_uni = 1'($urandom_range(0, 1));
      pif.uni_is_vacated_space = $urandom_range(0, 3) != 0;
      pif.is_vacated_space = $urandom_range(0, 3) != 0;
      pif.uni_parked_car = CW'($urandom_range(0, 2));
      pif.parked_car = CW'($urandom_range(0, 2));
      rst = $urandom_range(0, 599) == 0;
      @(negedge clk);
    end
    rst = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Producer side of the ParkingSystem occupancy interface.
- Turns raw gate sensor activity into the one-cycle car_entered and car_exited events that ParkingSystem counts, together with the matching university-car qualifiers.
- Opens the entry barrier only when ParkingSystem reports space for that car class. Opens the exit barrier only when the class count is non-zero.
- Also generates the hour-of-day value ParkingSystem consumes.

Parameters:
- CYCLES_PER_HOUR, 400: clk cycles per hour tick.
- GATE_TIMEOUT, 64: maximum cycles a barrier stays open waiting for the pass sensor.
- COUNT_W, 10: width of the occupancy count inputs.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- entry_req  input  1  car present at the entry sensor (level).
- entry_is_uni  input  1  presenting car is a university car; sampled in E_CHECK.
- entry_pass  input  1  car has passed the entry barrier (level).
- exit_req  input  1  car present at the exit sensor (level).
- exit_is_uni  input  1  exiting car is a university car; sampled in X_CHECK.
- exit_pass  input  1  car has passed the exit barrier.
- uni_is_vacated_space  input  1  from ParkingSystem: university space free.
- is_vacated_space  input  1  from ParkingSystem: general space free.
- uni_parked_car  input  COUNT_W  from ParkingSystem: university occupancy.
- parked_car  input  COUNT_W  from ParkingSystem: general occupancy.
- hour  output  5  hour of day, 0..23.
- car_entered  output  1  one-cycle entry event.
- is_uni_car_entered  output  1  class of the last entry event.
- car_exited  output  1  one-cycle exit event.
- is_uni_car_exited  output  1  class of the last exit event.
- entry_gate_open  output  1  entry barrier open command.
- exit_gate_open  output  1  exit barrier open command.
- entry_rejected  output  1  one-cycle pulse: no space for the presenting car.
- exit_rejected  output  1  one-cycle pulse: class count is zero.
- gate_timeout  output  1  one-cycle pulse: a barrier closed without a pass.

Behaviour:
- Reset values: every output 0. Internal state: hour=0, hour cycle counter=0, both FSMs in IDLE, timeout counters=0. Reset mid-operation closes both barriers in the next cycle; no event pulse is emitted for a car in transit.
- Hour generator:
  - Counter runs 0..CYCLES_PER_HOUR-1.
  - On wrap, hour increments; 23 wraps to 0.
  - Runs independently of the gate FSMs.
- Entry FSM states: E_IDLE, E_CHECK, E_OPEN, E_COMMIT, E_REJECT, E_CLEAR.
  - E_IDLE: entry_req=1 moves to E_CHECK.
  - E_CHECK: latch entry_is_uni into is_uni_car_entered. Space test uses uni_is_vacated_space if uni, else is_vacated_space. Space free goes to E_OPEN; otherwise E_REJECT.
  - E_OPEN: entry_gate_open=1 and the timeout counter runs.
    - entry_pass=1 goes to E_COMMIT.
    - After GATE_TIMEOUT cycles in E_OPEN without a pass, pulse gate_timeout and go to E_CLEAR.
  - E_COMMIT: car_entered=1 for exactly 1 cycle, gate closed, then E_CLEAR.
  - E_REJECT: entry_rejected=1 for 1 cycle, then E_CLEAR.
  - E_CLEAR: wait for entry_req=0, then E_IDLE. One event per car presence.
- Exit FSM states: X_IDLE, X_CHECK, X_OPEN, X_COMMIT, X_REJECT, X_CLEAR. Same structure as entry, with these differences:
  - Condition to open is (exit_is_uni ? uni_parked_car : parked_car) != 0.
  - is_uni_car_exited is latched in X_CHECK.
- Latency:
  - Request sampled high at cycle N gives gate open at N+2.
  - Pass sampled high at cycle M gives the event pulse at M+1.
- Outputs are registered and decoded from state. is_uni_* holds its value until the next CHECK of the same FSM, so it is stable around the pulse.
- Simultaneous commits: car_entered and car_exited never assert in the same cycle.
  - If both FSMs would enter COMMIT together, entry wins.
  - Exit stays in X_OPEN one extra cycle, with the gate still open, then commits. The timeout is not extended by this stall.
- Pass inputs outside OPEN states are ignored.
- Sensor inputs are assumed synchronous to clk.

Test Plan:
- Reset then idle, CYCLES_PER_HOUR=4:
  - hour steps 0,1,…,23,0 every 4 cycles.
  - All gate outputs stay 0.
- Entry accept (entry_is_uni=1, uni_is_vacated_space=1):
  - entry_req high at cycle 10 gives entry_gate_open high at 12.
  - entry_pass at 15 gives car_entered=1 only at 16, with is_uni_car_entered=1.
  - The gate drops at 16.
- Entry reject (entry_is_uni=0, is_vacated_space=0):
  - entry_rejected=1 pulses once; the gate never opens.
  - Holding entry_req high for 20 cycles produces no second pulse.
- Timeout (GATE_TIMEOUT=8):
  - Gate opens, no pass arrives: the gate is high exactly 8 cycles.
  - gate_timeout pulses once; no car_entered.
- Exit reject and accept:
  - parked_car=0 with exit_is_uni=0 gives exit_rejected.
  - parked_car=5 opens the gate; exit_pass gives car_exited with is_uni_car_exited=0.
- Collision and reset:
  - Entry and exit pass on the same cycle: car_entered at T+1, car_exited at T+2.
  - rst asserted while entry_gate_open=1: next cycle all outputs 0, no event pulse.
